// File: rtl/data_mem_access.sv
// Load/store execution unit driving a word-wide synchronous data SRAM.
// Handles byte-lane alignment, load extension and splits word-spanning accesses.
module data_mem_access #(
    parameter int MEM_AW           = 30,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    input  logic              i_write_mem_1B,
    input  logic              i_write_mem_2B,
    input  logic              i_write_mem_4B,
    input  logic              i_read_mem_1B,
    input  logic              i_read_mem_2B,
    input  logic              i_read_mem_4B,
    input  logic              i_extension_mem,
    output logic              o_resp_valid,
    output logic              o_resp_err,
    output logic [31:0]       o_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [3:0]        o_mem_wstrb,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_CAP, S_RESP} state_t;

    state_t            r_state;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_rdata;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [3:0]        r_mem_wstrb;
    logic [31:0]       r_mem_wdata;

    // Latched request context
    logic              r_store;
    logic              r_span;
    logic              r_ext;
    logic [1:0]        r_k;
    logic [1:0]        r_size;
    logic [3:0]        r_strb_hi;
    logic [31:0]       r_wdata_hi;
    logic [31:0]       r_lo;

    logic              w_legal;
    logic              w_store;
    logic              w_sz2;
    logic              w_sz4;
    logic [1:0]        w_k;
    logic [1:0]        w_size;
    logic              w_span;
    logic [3:0]        w_mask;
    logic [7:0]        w_strb8;
    logic [63:0]       w_wd64;
    logic [MEM_AW-1:0] w_word;

    assign w_legal = $onehot({i_write_mem_1B, i_write_mem_2B, i_write_mem_4B,
                              i_read_mem_1B, i_read_mem_2B, i_read_mem_4B});
    assign w_store = i_write_mem_1B | i_write_mem_2B | i_write_mem_4B;
    assign w_sz2   = i_write_mem_2B | i_read_mem_2B;
    assign w_sz4   = i_write_mem_4B | i_read_mem_4B;
    assign w_k     = i_addr[1:0];
    assign w_size  = w_sz4 ? 2'd2 : (w_sz2 ? 2'd1 : 2'd0);
    assign w_span  = (w_sz2 && (w_k == 2'd3)) || (w_sz4 && (w_k != 2'd0));
    assign w_mask  = w_sz4 ? 4'b1111 : (w_sz2 ? 4'b0011 : 4'b0001);
    // The upper nibble / upper word of the shifted values is exactly the
    // second-cycle lane set and data of a spanning store.
    assign w_strb8 = {4'b0000, w_mask} << w_k;
    assign w_wd64  = {32'd0, i_wdata} << {w_k, 3'b000};
    assign w_word  = i_addr[MEM_AW+1:2];

    function automatic logic [31:0] f_load(input logic [63:0] pair, input logic [1:0] k,
                                           input logic [1:0] size, input logic ext);
        logic [31:0] sh;
        sh = 32'(pair >> {k, 3'b000});
        case (size)
            2'd0:    f_load = {{24{ext & sh[7]}}, sh[7:0]};
            2'd1:    f_load = {{16{ext & sh[15]}}, sh[15:0]};
            default: f_load = sh;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata      <= 32'd0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wstrb  <= 4'd0;
            r_mem_wdata  <= 32'd0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_wstrb  <= 4'd0;
            r_mem_wdata  <= 32'd0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_store    <= w_store;
                        r_span     <= w_span;
                        r_ext      <= i_extension_mem;
                        r_k        <= w_k;
                        r_size     <= w_size;
                        r_strb_hi  <= w_strb8[7:4];
                        r_wdata_hi <= w_wd64[63:32];
                        if (!w_legal || (w_span && (ALLOW_MISALIGNED == 0))) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state     <= S_ACC0;
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= w_store;
                            r_mem_addr  <= w_word;
                            r_mem_wstrb <= w_store ? w_strb8[3:0] : 4'd0;
                            r_mem_wdata <= w_store ? w_wd64[31:0] : 32'd0;
                        end
                    end
                end
                S_ACC0: begin
                    if (r_span) begin
                        r_state     <= S_ACC1;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= r_store;
                        r_mem_addr  <= r_mem_addr + MEM_AW'(1);
                        r_mem_wstrb <= r_store ? r_strb_hi : 4'd0;
                        r_mem_wdata <= r_store ? r_wdata_hi : 32'd0;
                    end else if (r_store) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_state <= S_CAP;
                    end
                end
                S_ACC1: begin
                    // Read data of the first word arrives during this cycle
                    r_lo <= i_mem_rdata;
                    if (r_store) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_state <= S_CAP;
                    end
                end
                S_CAP: begin
                    r_rdata      <= f_load(r_span ? {i_mem_rdata, r_lo} : {32'd0, i_mem_rdata},
                                           r_k, r_size, r_ext);
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                end
                S_RESP: begin
                    r_rdata <= 32'd0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_resp_valid = r_resp_valid;
    assign o_resp_err   = r_resp_err;
    assign o_rdata      = r_rdata;
    assign o_mem_en     = r_mem_en;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wstrb  = r_mem_wstrb;
    assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access with a byte-lane SRAM model.
module tb_data_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr, wdata;
    logic [5:0]  stb;   // {w1, w2, w4, r1, r2, r4}
    logic        ext;
    logic        resp_valid, resp_err;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        nm_valid;
    logic        nm_ready, nm_resp_valid, nm_resp_err, nm_mem_en, nm_mem_we;
    logic [5:0]  nm_stb;
    logic [31:0] nm_addr;
    logic [31:0] nm_rdata, nm_mem_wdata;
    logic [29:0] nm_mem_addr;
    logic [3:0]  nm_mem_wstrb;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mem [logic [29:0]];
    logic [29:0] q_addr[$];
    logic        q_we[$];
    logic [3:0]  q_strb[$];
    logic [31:0] q_data[$];

    logic [31:0] res_rdata;
    logic        res_err;
    int          res_lat;
    logic        res_busy_ready;

    always #5 clk = ~clk;

    data_mem_access dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_addr(addr), .i_wdata(wdata),
        .i_write_mem_1B(stb[5]), .i_write_mem_2B(stb[4]), .i_write_mem_4B(stb[3]),
        .i_read_mem_1B(stb[2]), .i_read_mem_2B(stb[1]), .i_read_mem_4B(stb[0]),
        .i_extension_mem(ext), .o_resp_valid(resp_valid), .o_resp_err(resp_err),
        .o_rdata(rdata), .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wstrb(mem_wstrb), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    data_mem_access #(.MEM_AW(30), .ALLOW_MISALIGNED(0)) dut_nm (
        .i_clk(clk), .i_rst(rst), .i_req_valid(nm_valid), .o_req_ready(nm_ready),
        .i_addr(nm_addr), .i_wdata(32'd0),
        .i_write_mem_1B(nm_stb[5]), .i_write_mem_2B(nm_stb[4]), .i_write_mem_4B(nm_stb[3]),
        .i_read_mem_1B(nm_stb[2]), .i_read_mem_2B(nm_stb[1]), .i_read_mem_4B(nm_stb[0]),
        .i_extension_mem(1'b1), .o_resp_valid(nm_resp_valid), .o_resp_err(nm_resp_err),
        .o_rdata(nm_rdata), .o_mem_en(nm_mem_en), .o_mem_we(nm_mem_we),
        .o_mem_addr(nm_mem_addr), .o_mem_wstrb(nm_mem_wstrb), .o_mem_wdata(nm_mem_wdata),
        .i_mem_rdata(32'd0)
    );

    // SRAM model: lane writes, read data one cycle after the enable
    always @(posedge clk) begin
        if (mem_en) begin
            q_addr.push_back(mem_addr);
            q_we.push_back(mem_we);
            q_strb.push_back(mem_wstrb);
            q_data.push_back(mem_wdata);
            if (mem_we) begin
                logic [31:0] w;
                w = mem.exists(mem_addr) ? mem[mem_addr] : 32'd0;
                for (int i = 0; i < 4; i++)
                    if (mem_wstrb[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                mem[mem_addr] = w;
            end else begin
                mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'd0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] wd, input logic [5:0] s,
                       input logic e);
        int wait_n;
        wait_n = 0;
        while (!req_ready && wait_n < 20) begin
            @(posedge clk); #1; wait_n++;
        end
        @(negedge clk);
        q_addr.delete(); q_we.delete(); q_strb.delete(); q_data.delete();
        addr = a; wdata = wd; stb = s; ext = e; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; stb = 6'd0;
        res_busy_ready = req_ready;
        res_lat = 1;
        while (!resp_valid && res_lat < 20) begin
            @(posedge clk); #1; res_lat++;
        end
        check("resp_timeout", {31'd0, resp_valid}, 32'd1);
        res_rdata = rdata;
        res_err   = resp_err;
        @(posedge clk); #1;
        check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; req_valid = 1'b0; addr = 0; wdata = 0; stb = 0; ext = 0;
        nm_valid = 1'b0; nm_stb = 0; nm_addr = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);

        // Aligned word store and load
        run(32'h100, 32'hDEADBEEF, 6'b001000, 1'b0);
        check("sw_lat", res_lat, 2);
        check("sw_busy", {31'd0, res_busy_ready}, 32'd0);
        check("sw_naccess", q_addr.size(), 1);
        check("sw_addr", {2'b0, q_addr[0]}, 32'h40);
        check("sw_strb", {28'd0, q_strb[0]}, 32'hF);
        check("sw_rdata0", res_rdata, 32'd0);
        run(32'h100, 32'd0, 6'b000001, 1'b1);
        check("lw_lat", res_lat, 3);
        check("lw_data", res_rdata, 32'hDEADBEEF);
        check("lw_we", {31'd0, q_we[0]}, 32'd0);
        check("lw_strb", {28'd0, q_strb[0]}, 32'd0);

        // Byte lanes
        run(32'h103, 32'h80, 6'b100000, 1'b0);
        check("sb_strb", {28'd0, q_strb[0]}, 32'h8);
        check("sb_wdata", q_data[0], 32'h80000000);
        run(32'h103, 32'd0, 6'b000100, 1'b1);
        check("lb", res_rdata, 32'hFFFFFF80);
        run(32'h103, 32'd0, 6'b000100, 1'b0);
        check("lbu", res_rdata, 32'h00000080);

        // Halfword at offset 2
        run(32'h202, 32'h8001, 6'b010000, 1'b0);
        check("sh_strb", {28'd0, q_strb[0]}, 32'hC);
        check("sh_wdata", q_data[0], 32'h80010000);
        run(32'h202, 32'd0, 6'b000010, 1'b1);
        check("lh", res_rdata, 32'hFFFF8001);
        run(32'h202, 32'd0, 6'b000010, 1'b0);
        check("lhu", res_rdata, 32'h00008001);

        // Spanning word load
        run(32'h100, 32'h44332211, 6'b001000, 1'b0);
        run(32'h104, 32'h88776655, 6'b001000, 1'b0);
        run(32'h101, 32'd0, 6'b000001, 1'b1);
        check("lw_span_lat", res_lat, 4);
        check("lw_span_n", q_addr.size(), 2);
        check("lw_span_a0", {2'b0, q_addr[0]}, 32'h40);
        check("lw_span_a1", {2'b0, q_addr[1]}, 32'h41);
        check("lw_span_data", res_rdata, 32'h55443322);

        // Spanning word store
        run(32'h103, 32'hAABBCCDD, 6'b001000, 1'b0);
        check("sw_span_lat", res_lat, 3);
        check("sw_span_s0", {28'd0, q_strb[0]}, 32'h8);
        check("sw_span_d0", q_data[0], 32'hDD000000);
        check("sw_span_s1", {28'd0, q_strb[1]}, 32'h7);
        check("sw_span_d1", q_data[1], 32'h00AABBCC);
        run(32'h103, 32'd0, 6'b000001, 1'b0);
        check("lw_span_back", res_rdata, 32'hAABBCCDD);
        run(32'h103, 32'd0, 6'b000010, 1'b1);
        check("lh_span", res_rdata, 32'hFFFFCCDD);

        // Illegal strobe combinations
        run(32'h100, 32'd0, 6'b000110, 1'b0);
        check("err2_lat", res_lat, 1);
        check("err2_flag", {31'd0, res_err}, 32'd1);
        check("err2_noacc", q_addr.size(), 0);
        run(32'h100, 32'd0, 6'b000000, 1'b0);
        check("err0_flag", {31'd0, res_err}, 32'd1);
        check("err0_noacc", q_addr.size(), 0);

        // Misaligned rejection on the second instance
        @(negedge clk);
        nm_addr = 32'h3; nm_stb = 6'b000010; nm_valid = 1'b1;
        @(posedge clk); #1;
        nm_valid = 1'b0; nm_stb = 0;
        check("nm_valid", {31'd0, nm_resp_valid}, 32'd1);
        check("nm_err", {31'd0, nm_resp_err}, 32'd1);
        check("nm_mem_en", {31'd0, nm_mem_en}, 32'd0);
        @(posedge clk); #1;

        // Word address wrap
        run(32'hFFFFFFFE, 32'h1234, 6'b010000, 1'b0);
        run(32'h0, 32'hCAFEF00D, 6'b001000, 1'b0);
        run(32'hFFFFFFFE, 32'd0, 6'b000001, 1'b0);
        check("wrap_a0", {2'b0, q_addr[0]}, 32'h3FFFFFFF);
        check("wrap_a1", {2'b0, q_addr[1]}, 32'h0);
        check("wrap_data", res_rdata, 32'hF00D1234);

        // Reset during second access of a spanning load
        @(negedge clk);
        addr = 32'h101; stb = 6'b000001; ext = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; stb = 0;
        @(posedge clk); #1;
        check("rmid_acc1_en", {31'd0, mem_en}, 32'd1);
        check("rmid_acc1_addr", {2'b0, mem_addr}, 32'h41);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rmid_ready", {31'd0, req_ready}, 32'd1);
        check("rmid_mem_en", {31'd0, mem_en}, 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        check("rmid_no_resp", seen, 0);
        check("rmid_ready_after", {31'd0, req_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_access.md
Name: data_mem_access

Overview:
- Sequential load/store execution unit sitting downstream of the instruction decoder.
- Consumes the decoder's size strobes (read/write 1B/2B/4B) and the sign-extension flag.
- Drives a 32-bit synchronous word-wide data SRAM: byte-lane strobes, little-endian alignment, load sign/zero extension.
- Splits misaligned (word-spanning) accesses into two memory cycles.

Parameters:
- MEM_AW, 30, word-address width of the SRAM port; mem_addr = addr[MEM_AW+1:2], upper bits dropped.
- ALLOW_MISALIGNED, 1, when 1 spanning accesses are split into two cycles; when 0 they are rejected with resp_err.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (IDLE only)
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- write_mem_1B, write_mem_2B, write_mem_4B  in  1 each  store size strobes
- read_mem_1B, read_mem_2B, read_mem_4B  in  1 each  load size strobes
- extension_mem  in  1  1 = sign-extend load, 0 = zero-extend
- resp_valid  out  1  one-cycle completion pulse, no backpressure
- resp_err  out  1  qualifies resp_valid: illegal or rejected request
- rdata  out  32  extended load result, valid with resp_valid, 0 for stores
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  MEM_AW  SRAM word address
- mem_wstrb  out  4  byte-lane write enables, lane i = bits [8i+7:8i]
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en && !mem_we

Behaviour:
- Clocking and reset: single clock; synchronous active-high reset.
- States: IDLE, ACC0, ACC1, CAP, RESP.
- Reset values: state IDLE, req_ready 1 after reset deasserts, all other outputs 0.
- Reset mid-operation aborts the access; no resp_valid is produced. A second SRAM word may be left partially written.
- Accept (cycle T): req_valid && req_ready. The unit latches addr, wdata, the strobes, extension_mem and k = addr[1:0].
- Legality check (accepted request):
  - Exactly one of the six strobes must be high. Zero or several high -> RESP at T+1 with resp_err=1 and no SRAM access.
  - Spanning = (2B and k==3) or (4B and k!=0).
  - Spanning with ALLOW_MISALIGNED=0 -> error response at T+1, no SRAM access.
- ACC0 (T+1):
  - mem_en=1, mem_we=store, mem_addr = word(addr).
  - Store: mem_wstrb = size mask << k, truncated to 4 bits; mem_wdata = wdata << 8k.
  - Next state: ACC1 if spanning; otherwise CAP for loads, RESP for stores.
- ACC1 (spanning only, T+2):
  - mem_en=1, mem_addr = word(addr)+1, wrapping modulo 2^MEM_AW.
  - Store: mem_wstrb = lanes 0..(k+size-5); mem_wdata = wdata >> 8(4-k).
  - Load: also captures mem_rdata as low buffer word.
  - Next state: CAP for loads, RESP for stores.
- CAP (loads): captures mem_rdata as the high word if spanning, else as the low word. mem_en=0.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=1 again the following cycle.
- Load assembly:
  - raw = {hi, lo} >> 8k, take low 8/16/32 bits.
  - extension_mem=1 replicates the top bit of the raw field; extension_mem=0 fills with 0.
  - extension_mem is ignored for 4B and for stores.
- Latency, accept to resp_valid:
  - aligned store 2 cycles
  - spanning store 3
  - aligned load 3
  - spanning load 4
  - error 1
- mem_en=0 in IDLE, CAP and RESP; mem_we/mem_wstrb/mem_wdata are 0 whenever mem_en=0 or the access is a load.
- Request inputs are ignored while req_ready=0. The requester holds a request until accepted.

Test Plan:
- Aligned word: store 0xDEADBEEF at addr 0x100, then load 4B at 0x100.
  - Store: ACC0 has mem_addr=0x40, wstrb=4'b1111.
  - Load: resp_valid at T+3, rdata=0xDEADBEEF.
- Byte lanes: sb 0x80 at addr 0x103 -> wstrb=4'b1000, mem_wdata=0x80000000. Then:
  - lb at 0x103 -> 0xFFFFFF80
  - lbu at 0x103 -> 0x00000080
- Half at offset 2: sh 0x8001 at 0x202 -> wstrb=4'b1100. lh at 0x202 -> 0xFFFF8001; lhu -> 0x00008001.
- Spanning word: memory words 0x40=0x44332211, 0x41=0x88776655; load 4B at 0x101.
  - Two SRAM reads at 0x40 and 0x41; rdata=0x55443322 at T+4.
  - Store 0xAABBCCDD at 0x103: wstrb 4'b1000 with data 0xDD000000, then 4'b0111 with data 0x00AABBCC.
- Errors and wrap:
  - Two strobes high -> resp_err=1 at T+1, mem_en never asserted.
  - ALLOW_MISALIGNED=0 with lh at 0x3 -> resp_err=1.
  - Word load at 0xFFFFFFFE (MEM_AW=30) -> second mem_addr=0.
- Reset mid-op: assert rst during ACC1 of a spanning load -> next cycle state IDLE, no resp_valid, req_ready=1 after release.
